// File: rtl/image_repack_pkg.sv
// Shared types and constants for the image_repack width converter.
package image_repack_pkg;

  localparam int unsigned CFG_DWIDTH_DEF = 32;
  localparam int unsigned CFG_AWIDTH_DEF = 5;
  localparam int unsigned DEPTH_NB_DEF   = 16;
  localparam int unsigned GROUP_NB_DEF   = 4;
  localparam int unsigned IMG_WIDTH_DEF  = 16;

  // Config address of the repack frame-length register.
  localparam int unsigned CFG_REPACK = 7;

  // Frame length / word counter width; taken from cfg_data[15:0].
  localparam int unsigned LEN_W = 16;
  typedef logic [LEN_W-1:0] frame_len_t;

  // Occupancy of the single-word holding register.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // Index width that stays legal when only one item exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_repack_if.sv
// Config, result-stream and image-stream signals of image_repack.
// slave = the repacker's view, master = the surrounding layer logic.
interface image_repack_if
  import image_repack_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH = CFG_DWIDTH_DEF,
  parameter int unsigned CFG_AWIDTH = CFG_AWIDTH_DEF,
  parameter int unsigned DEPTH_NB   = DEPTH_NB_DEF,
  parameter int unsigned GROUP_NB   = GROUP_NB_DEF,
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF
);

  logic [CFG_DWIDTH-1:0]         cfg_data;
  logic [CFG_AWIDTH-1:0]         cfg_addr;
  logic                          cfg_valid;
  logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus;
  logic                          result_val;
  logic                          result_rdy;
  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus;
  logic                          image_last;
  logic                          image_val;
  logic                          image_rdy;

  modport master (
    output cfg_data, cfg_addr, cfg_valid, result_bus, result_val, image_rdy,
    input  result_rdy, image_bus, image_last, image_val
  );

  modport slave (
    input  cfg_data, cfg_addr, cfg_valid, result_bus, result_val, image_rdy,
    output result_rdy, image_bus, image_last, image_val
  );

endinterface

// File: rtl/image_repack_frame.sv
// Frame length register, completed-word counter and last-word compare.
// Only instantiated when IMAGE_REPACK_LAST_EN is defined.
module image_repack_frame
  import image_repack_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH = CFG_DWIDTH_DEF,
  parameter int unsigned CFG_AWIDTH = CFG_AWIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data_i,
  input  logic [CFG_AWIDTH-1:0] cfg_addr_i,
  input  logic                  cfg_valid_i,
  input  logic                  last_beat_i,
  input  logic                  word_done_i,
  output logic                  last_o
);

  frame_len_t len_q, len_d;
  frame_len_t cnt_q, cnt_d;
  frame_len_t len_eff;
  logic       at_end;

  logic [CFG_DWIDTH-LEN_W-1:0] unused_cfg_hi;
  assign unused_cfg_hi = cfg_data_i[CFG_DWIDTH-1:LEN_W];

  // Length and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= frame_len_t'(1);
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  // Compare against the live length so a shrink ends the frame on the current word
  always_comb begin
    len_eff = (len_q == '0) ? frame_len_t'(1) : len_q;
    at_end  = (cnt_q >= (len_eff - frame_len_t'(1)));
    last_o  = last_beat_i && at_end;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (cfg_valid_i && (cfg_addr_i == CFG_AWIDTH'(CFG_REPACK))) begin
      len_d = cfg_data_i[LEN_W-1:0];
    end
    if (word_done_i) begin
      cnt_d = at_end ? '0 : cnt_q + frame_len_t'(1);
    end
  end

endmodule

// File: rtl/image_repack.sv
// Splits each DEPTH_NB-pixel result word into GROUP_NB-pixel image beats,
// lowest lanes first, and flags the final beat of each frame.
// Optional: IMAGE_REPACK_LAST_EN builds the frame counter; otherwise image_last is 0.
module image_repack
  import image_repack_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH = CFG_DWIDTH_DEF,
  parameter int unsigned CFG_AWIDTH = CFG_AWIDTH_DEF,
  parameter int unsigned DEPTH_NB   = DEPTH_NB_DEF,
  parameter int unsigned GROUP_NB   = GROUP_NB_DEF,
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  image_repack_if.slave bus
);

  localparam int unsigned BEATS   = DEPTH_NB / GROUP_NB;
  localparam int unsigned BEAT_W  = idx_width(BEATS);
  localparam int unsigned SLICE_W = GROUP_NB * IMG_WIDTH;
  localparam int unsigned WORD_W  = DEPTH_NB * IMG_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  slot_e               slot_q, slot_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                on_last_beat;
  logic                frame_last_beat;
  logic                beat_xfer;
  logic                word_done;
  logic                word_accept;
  logic                result_rdy;
  logic                image_val;
  logic                image_last;
  logic [SLICE_W-1:0]  image_bus;

  // Occupancy, word and beat registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= SLOT_EMPTY;
      word_q <= '0;
      beat_q <= '0;
    end else begin
      slot_q <= slot_d;
      word_q <= word_d;
      beat_q <= beat_d;
    end
  end

  // Next state: a word accepted on the last beat's transfer replaces it without a bubble
  always_comb begin
    slot_d = slot_q;
    word_d = word_q;
    beat_d = beat_q;
    if (word_accept) begin
      slot_d = SLOT_FULL;
      word_d = bus.result_bus;
      beat_d = '0;
    end else if (word_done) begin
      slot_d = SLOT_EMPTY;
      beat_d = '0;
    end else if (beat_xfer) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // Handshake outputs and lane select
  always_comb begin
    on_last_beat    = (beat_q == LAST_BEAT);
    image_val       = (slot_q == SLOT_FULL);
    frame_last_beat = image_val && on_last_beat;
    beat_xfer       = image_val && bus.image_rdy;
    word_done       = beat_xfer && on_last_beat;
    result_rdy      = rst && (!image_val || (on_last_beat && bus.image_rdy));
    word_accept     = bus.result_val && result_rdy;
    image_bus       = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        image_bus = word_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

`ifdef IMAGE_REPACK_LAST_EN
  image_repack_frame #(
    .CFG_DWIDTH (CFG_DWIDTH),
    .CFG_AWIDTH (CFG_AWIDTH)
  ) u_frame (
    .clk         (clk),
    .rst         (rst),
    .cfg_data_i  (bus.cfg_data),
    .cfg_addr_i  (bus.cfg_addr),
    .cfg_valid_i (bus.cfg_valid),
    .last_beat_i (frame_last_beat),
    .word_done_i (word_done),
    .last_o      (image_last)
  );
`else
  logic [CFG_DWIDTH-1:0] unused_cfg_data;
  logic                  unused_cfg_ctl;
  logic                  unused_last_beat;
  assign unused_cfg_data  = bus.cfg_data;
  assign unused_cfg_ctl   = bus.cfg_valid & (bus.cfg_addr == CFG_AWIDTH'(CFG_REPACK));
  assign unused_last_beat = frame_last_beat;
  assign image_last       = 1'b0;
`endif

  assign bus.result_rdy = result_rdy;
  assign bus.image_val  = image_val;
  assign bus.image_bus  = image_bus;
  assign bus.image_last = image_last;

endmodule

// File: tb/tb_image_repack.sv
// Self-checking bench for image_repack: directed scenarios with random data,
// checked against a queue-based beat scoreboard and a frame-position model.
module tb_image_repack;
  import image_repack_pkg::*;

  localparam int unsigned CDW   = 32;
  localparam int unsigned CAW   = 5;
  localparam int unsigned DN    = 16;
  localparam int unsigned GN    = 4;
  localparam int unsigned IW    = 16;
  localparam int unsigned BEATS = DN / GN;
  localparam int unsigned SW    = GN * IW;
  localparam int unsigned WW    = DN * IW;
  localparam bit LAST_ON =
`ifdef IMAGE_REPACK_LAST_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [SW-1:0] data;
    bit            word_end;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  beat_t       sb[$];
  int          xlog[$];
  bit          llog[$];
  int unsigned m_cnt = 0;
  int unsigned m_len = 1;
  bit          hold_pending = 1'b0;
  logic [SW-1:0] held_bus;
  logic        held_last;
  int          rdy_mode = 0;
  int unsigned rdy_phase = 0;

  image_repack_if #(
    .CFG_DWIDTH (CDW), .CFG_AWIDTH (CAW), .DEPTH_NB (DN), .GROUP_NB (GN), .IMG_WIDTH (IW)
  ) bus ();

  image_repack #(
    .CFG_DWIDTH (CDW), .CFG_AWIDTH (CAW), .DEPTH_NB (DN), .GROUP_NB (GN), .IMG_WIDTH (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame position model: a word closes its frame once it is the len-th word since the last close.
  function automatic bit model_last(input bit word_end);
    int unsigned frame_len;
    frame_len = (m_len == 0) ? 1 : m_len;
    return LAST_ON && word_end && (m_cnt + 1 >= frame_len);
  endfunction

  // Downstream ready patterns
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: bus.image_rdy = 1'b1;
      1: begin
        bus.image_rdy = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
        rdy_phase++;
      end
      default: bus.image_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples mid-cycle, what it sees transfers on the next rising edge
  always @(negedge clk) begin
    beat_t b;
    beat_t nb;
    bit    exp_last;
    if (rst) begin
      if (hold_pending) begin
        chk("hold_bus", 64'(bus.image_bus), 64'(held_bus));
        chk("hold_last", 64'(bus.image_last), 64'(held_last));
        chk("hold_val", 64'(bus.image_val), 64'd1);
        hold_pending = 1'b0;
      end
      if (bus.image_val && bus.image_rdy) begin
        chk("sb_nonempty", 64'(sb.size() == 0), 64'd0);
        if (sb.size() != 0) begin
          b = sb.pop_front();
          exp_last = model_last(b.word_end);
          chk("beat_data", 64'(bus.image_bus), 64'(b.data));
          chk("beat_last", 64'(bus.image_last), 64'(exp_last));
          if (b.word_end) m_cnt = exp_last ? 0 : m_cnt + 1;
        end
        xlog.push_back(cyc);
        llog.push_back(bus.image_last);
      end else if (bus.image_val) begin
        hold_pending = 1'b1;
        held_bus     = bus.image_bus;
        held_last    = bus.image_last;
      end else begin
        chk("idle_last", 64'(bus.image_last), 64'd0);
      end
      if (bus.result_val && bus.result_rdy) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          nb.data     = SW'(bus.result_bus >> (k * SW));
          nb.word_end = (k == BEATS - 1);
          sb.push_back(nb);
        end
      end
      if (bus.cfg_valid && (bus.cfg_addr == CAW'(CFG_REPACK))) m_len = bus.cfg_data[15:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    bit acc;
    acc = 1'b0;
    bus.result_bus = w;
    bus.result_val = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = bus.result_rdy;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic cfg_write(input logic [CAW-1:0] addr, input logic [CDW-1:0] data);
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || bus.image_val) && i < 400) begin
      tick();
      i++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < int'(WW / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [63:0] last_mask();
    logic [63:0] m;
    m = '0;
    foreach (llog[i]) if (llog[i] && i < 64) m[i] = 1'b1;
    return m;
  endfunction

  task automatic clear_logs();
    xlog.delete();
    llog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w;
    logic [63:0]   exp1 [4];
    exp1[0] = 64'h0003000200010000;
    exp1[1] = 64'h0007000600050004;
    exp1[2] = 64'h000B000A00090008;
    exp1[3] = 64'h000F000E000D000C;

    bus.result_val = 1'b0;
    bus.result_bus = '0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;

    // Reset state
    #12;
    chk("rst_image_val", 64'(bus.image_val), 64'd0);
    chk("rst_image_last", 64'(bus.image_last), 64'd0);
    chk("rst_image_bus", 64'(bus.image_bus), 64'd0);
    chk("rst_result_rdy", 64'(bus.result_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rdy_after_reset", 64'(bus.result_rdy), 64'd1);
    tick();

    // Lane ordering with an incrementing-pixel word
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(i);
    send_word(w);
    bus.result_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("s1_val", 64'(bus.image_val), 64'd1);
      chk("s1_bus", 64'(bus.image_bus), exp1[k]);
      tick();
    end
    drain();

    // Length 3, six words back to back
    cfg_write(CAW'(CFG_REPACK), 32'd3);
    clear_logs();
    for (int i = 0; i < 6; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    drain();
    chk("s2_beats", 64'(xlog.size()), 64'd24);
    chk("s2_span", 64'(xlog[23] - xlog[0]), 64'd23);
    chk("s2_last_mask", last_mask(), LAST_ON ? 64'h0080_0800 : 64'd0);

    // Stalls with ready pattern 1-0-0-1
    rdy_mode  = 1;
    rdy_phase = 0;
    cfg_write(CAW'(CFG_REPACK), 32'd2);
    clear_logs();
    for (int i = 0; i < 4; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    drain();
    chk("s3_beats", 64'(xlog.size()), 64'd16);
    chk("s3_last_mask", last_mask(), LAST_ON ? 64'h8080 : 64'd0);

    // Length 0 behaves as 1, random stalls
    rdy_mode = 2;
    cfg_write(CAW'(CFG_REPACK), 32'd0);
    clear_logs();
    for (int i = 0; i < 3; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    drain();
    rdy_mode = 0;
    chk("s4_beats", 64'(xlog.size()), 64'd12);
    chk("s4_last_mask", last_mask(), LAST_ON ? 64'h888 : 64'd0);

    // Length 5, three words, then shrink to 2; a write to another address is ignored
    cfg_write(CAW'(CFG_REPACK), 32'd5);
    cfg_write(CAW'(CFG_REPACK + 1), 32'd1);
    clear_logs();
    for (int i = 0; i < 3; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    drain();
    chk("s5a_last_mask", last_mask(), 64'd0);
    cfg_write(CAW'(CFG_REPACK), 32'd2);
    clear_logs();
    for (int i = 0; i < 3; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    drain();
    chk("s5b_last_mask", last_mask(), LAST_ON ? 64'h808 : 64'd0);

    // Reset during beat 2 of the third word of a length-3 frame
    cfg_write(CAW'(CFG_REPACK), 32'd3);
    for (int i = 0; i < 3; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    tick();
    tick();
    chk("s6_val_before_rst", 64'(bus.image_val), 64'd1);
    rst = 1'b0;
    sb.delete();
    m_cnt        = 0;
    m_len        = 1;
    hold_pending = 1'b0;
    #1;
    chk("s6_rst_val", 64'(bus.image_val), 64'd0);
    chk("s6_rst_last", 64'(bus.image_last), 64'd0);
    chk("s6_rst_bus", 64'(bus.image_bus), 64'd0);
    chk("s6_rst_rdy", 64'(bus.result_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    clear_logs();
    w = rand_word();
    send_word(w);
    bus.result_val = 1'b0;
    chk("s6_first_beat", 64'(bus.image_bus), w[63:0]);
    drain();
    chk("s6a_last_mask", last_mask(), LAST_ON ? 64'h8 : 64'd0);
    cfg_write(CAW'(CFG_REPACK), 32'd3);
    clear_logs();
    for (int i = 0; i < 3; i++) send_word(rand_word());
    bus.result_val = 1'b0;
    drain();
    chk("s6b_last_mask", last_mask(), LAST_ON ? 64'h800 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
